// File: rtl/rf_write_arbiter_pkg.sv
// rf_write_arbiter_pkg: shared register-file write types and arbiter state encoding.
package rf_write_arbiter_pkg;
    localparam int REG_ID_W = 6;
    localparam int DATA_W   = 32;

    typedef struct packed {
        logic [REG_ID_W-1:0] id;
        logic [DATA_W-1:0]   data;
    } rf_write_t;

    typedef enum logic {ARB, FORCE} arb_state_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with wrapping pointers and a separate occupancy count.
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           din,
    output logic [W-1:0]           dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          push_ok, pop_ok;

    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        end
    end

    always_ff @(posedge clk)
        if (push_ok) mem[wr_ptr] <= din;
endmodule

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: shares the register-file write port between WB (priority)
// and a FIFO-buffered multi-cycle unit, with a starvation-driven stall request.
module rf_write_arbiter #(
    parameter int DEPTH    = 4,
    parameter int MAX_WAIT = 8,
    parameter int ID_W     = 6,
    parameter int DATA_W   = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wb_valid,
    input  logic [ID_W-1:0]        wb_id,
    input  logic [DATA_W-1:0]      wb_data,
    input  logic                   mc_valid,
    output logic                   mc_ready,
    input  logic [ID_W-1:0]        mc_id,
    input  logic [DATA_W-1:0]      mc_data,
    output logic                   write_en,
    output logic [ID_W-1:0]        write_id,
    output logic [DATA_W-1:0]      write_data,
    output logic                   stall_req,
    output logic [$clog2(DEPTH):0] mc_count
);
    import rf_write_arbiter_pkg::*;
    localparam int WW = $clog2(MAX_WAIT + 1);

    logic [ID_W+DATA_W-1:0] head;
    logic                   full, empty, push, pop, wb_req, head_lost, grant;
    logic [ID_W-1:0]        head_id, next_id;
    logic [DATA_W-1:0]      next_data;
    logic [WW-1:0]          wait_cnt, wait_cnt_nxt;
    arb_state_t             state, state_nxt;

    sync_fifo #(.DEPTH(DEPTH), .W(ID_W + DATA_W)) u_fifo (
        .clk(clk), .reset(reset), .push(push), .pop(pop),
        .din({mc_id, mc_data}), .dout(head),
        .full(full), .empty(empty), .count(mc_count)
    );

    assign mc_ready  = !full;
    assign push      = mc_valid && mc_ready;
    assign head_id   = head[ID_W+DATA_W-1:DATA_W];
    // A write to r0 is no request at all: WB with id 0 yields the slot to MC.
    assign wb_req    = wb_valid && wb_id != '0;
    assign pop       = !empty && !wb_req;
    assign head_lost = !empty && !pop;
    assign grant     = wb_req || (pop && head_id != '0);
    assign next_id   = wb_req ? wb_id : head_id;
    assign next_data = wb_req ? wb_data : head[DATA_W-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            write_en   <= 1'b0;
            write_id   <= '0;
            write_data <= '0;
        end else begin
            write_en <= grant;
            if (grant) begin
                write_id   <= next_id;
                write_data <= next_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ARB;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = (state == ARB && head_lost) ? wait_cnt + WW'(1) : '0;
        if (state == ARB)
            state_nxt = (head_lost && wait_cnt == WW'(MAX_WAIT - 1)) ? FORCE : ARB;
        else
            state_nxt = pop ? ARB : FORCE;
    end

    always_comb stall_req = state == FORCE;
endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: directed self-checking bench for rf_write_arbiter.
module tb_rf_write_arbiter;
    logic        clk = 0, reset = 1;
    logic        wb_valid = 0, mc_valid = 0;
    logic [5:0]  wb_id = 0, mc_id = 0;
    logic [31:0] wb_data = 0, mc_data = 0;
    logic        mc_ready, write_en, stall_req;
    logic [5:0]  write_id;
    logic [31:0] write_data;
    logic [2:0]  mc_count;
    int          vectors = 0, miscompares = 0;

    rf_write_arbiter #(.DEPTH(4), .MAX_WAIT(8), .ID_W(6), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .wb_valid(wb_valid), .wb_id(wb_id), .wb_data(wb_data),
        .mc_valid(mc_valid), .mc_ready(mc_ready), .mc_id(mc_id), .mc_data(mc_data),
        .write_en(write_en), .write_id(write_id), .write_data(write_data),
        .stall_req(stall_req), .mc_count(mc_count)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1;
        tick();
        tick();
        reset = 0;
        tick();
        vectors++; if (write_en !== 1'b0) begin miscompares++; $display("FAIL reset_write_en got %b exp 0", write_en); end
        vectors++; if (stall_req !== 1'b0) begin miscompares++; $display("FAIL reset_stall got %b exp 0", stall_req); end
        vectors++; if (mc_ready !== 1'b1) begin miscompares++; $display("FAIL reset_mc_ready got %b exp 1", mc_ready); end
        vectors++; if (mc_count !== 3'd0) begin miscompares++; $display("FAIL reset_mc_count got %0d exp 0", mc_count); end
        vectors++; if (write_id !== 6'd0 || write_data !== 32'd0) begin miscompares++; $display("FAIL reset_write_fields got %0d/%h exp 0/0", write_id, write_data); end
    endtask

    task automatic test_wb_only;
        wb_valid = 1; wb_id = 5; wb_data = 32'hDEADBEEF;
        tick();
        vectors++; if (write_en !== 1'b1 || write_id !== 6'd5 || write_data !== 32'hDEADBEEF) begin miscompares++; $display("FAIL wb_only got en=%b id=%0d data=%h exp 1/5/deadbeef", write_en, write_id, write_data); end
        wb_valid = 0;
        tick();
        vectors++; if (write_en !== 1'b0 || write_id !== 6'd5 || write_data !== 32'hDEADBEEF) begin miscompares++; $display("FAIL wb_hold got en=%b id=%0d data=%h exp 0/5/deadbeef", write_en, write_id, write_data); end
    endtask

    task automatic test_conflict;
        wb_valid = 1; wb_id = 3; wb_data = 32'h11;
        mc_valid = 1; mc_id = 7; mc_data = 32'h22;
        tick();
        vectors++; if (write_en !== 1'b1 || write_id !== 6'd3 || write_data !== 32'h11) begin miscompares++; $display("FAIL conflict_wb got en=%b id=%0d data=%h exp 1/3/11", write_en, write_id, write_data); end
        vectors++; if (mc_count !== 3'd1) begin miscompares++; $display("FAIL conflict_count1 got %0d exp 1", mc_count); end
        wb_valid = 0; mc_valid = 0;
        tick();
        vectors++; if (write_en !== 1'b1 || write_id !== 6'd7 || write_data !== 32'h22) begin miscompares++; $display("FAIL conflict_mc got en=%b id=%0d data=%h exp 1/7/22", write_en, write_id, write_data); end
        vectors++; if (mc_count !== 3'd0) begin miscompares++; $display("FAIL conflict_count0 got %0d exp 0", mc_count); end
        tick();
        vectors++; if (write_en !== 1'b0) begin miscompares++; $display("FAIL conflict_idle got %b exp 0", write_en); end
    endtask

    task automatic test_full;
        wb_valid = 1; wb_id = 1;
        for (int i = 0; i < 4; i++) begin
            wb_data = 32'h100 + i;
            mc_valid = 1; mc_id = 6'(10 + i); mc_data = 32'hA0 + i;
            tick();
            vectors++; if (mc_count !== 3'(i + 1)) begin miscompares++; $display("FAIL full_count%0d got %0d exp %0d", i, mc_count, i + 1); end
        end
        vectors++; if (mc_ready !== 1'b0) begin miscompares++; $display("FAIL full_ready got %b exp 0", mc_ready); end
        vectors++; if (write_en !== 1'b1 || write_id !== 6'd1 || write_data !== 32'h103) begin miscompares++; $display("FAIL full_wb got en=%b id=%0d data=%h exp 1/1/103", write_en, write_id, write_data); end
        mc_id = 14; mc_data = 32'hEE;
        tick();
        vectors++; if (mc_count !== 3'd4) begin miscompares++; $display("FAIL full_reject got %0d exp 4", mc_count); end
        wb_valid = 0; mc_valid = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++; if (write_en !== 1'b1 || write_id !== 6'(10 + i) || write_data !== 32'hA0 + i) begin miscompares++; $display("FAIL drain%0d got en=%b id=%0d data=%h exp 1/%0d/%h", i, write_en, write_id, write_data, 10 + i, 32'hA0 + i); end
        end
        tick();
        vectors++; if (write_en !== 1'b0 || mc_count !== 3'd0) begin miscompares++; $display("FAIL drain_done got en=%b count=%0d exp 0/0", write_en, mc_count); end
    endtask

    task automatic test_starvation;
        wb_valid = 1; wb_id = 2; wb_data = 32'h2;
        mc_valid = 1; mc_id = 20; mc_data = 32'h55;
        tick();
        mc_valid = 0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            vectors++; if (stall_req !== (k == 8)) begin miscompares++; $display("FAIL starve_cycle%0d got %b exp %b", k, stall_req, k == 8); end
        end
        wb_valid = 0;
        tick();
        vectors++; if (write_en !== 1'b1 || write_id !== 6'd20 || write_data !== 32'h55) begin miscompares++; $display("FAIL starve_write got en=%b id=%0d data=%h exp 1/20/55", write_en, write_id, write_data); end
        vectors++; if (stall_req !== 1'b0) begin miscompares++; $display("FAIL starve_release got %b exp 0", stall_req); end
    endtask

    task automatic test_x0;
        wb_valid = 1; wb_id = 0; wb_data = 32'hBAD;
        mc_valid = 1; mc_id = 9; mc_data = 32'h99;
        tick();
        vectors++; if (write_en !== 1'b0) begin miscompares++; $display("FAIL x0_wb got %b exp 0", write_en); end
        mc_valid = 0;
        tick();
        vectors++; if (write_en !== 1'b1 || write_id !== 6'd9 || write_data !== 32'h99) begin miscompares++; $display("FAIL x0_drain got en=%b id=%0d data=%h exp 1/9/99", write_en, write_id, write_data); end
        wb_valid = 0;
        mc_valid = 1; mc_id = 0; mc_data = 32'h77;
        tick();
        vectors++; if (write_en !== 1'b0 || mc_count !== 3'd1) begin miscompares++; $display("FAIL mc0_push got en=%b count=%0d exp 0/1", write_en, mc_count); end
        mc_valid = 0;
        tick();
        vectors++; if (write_en !== 1'b0 || mc_count !== 3'd0 || write_id !== 6'd9) begin miscompares++; $display("FAIL mc0_drop got en=%b count=%0d id=%0d exp 0/0/9", write_en, mc_count, write_id); end
    endtask

    task automatic test_reset_mid;
        wb_valid = 1; wb_id = 4; wb_data = 32'h4;
        for (int i = 0; i < 3; i++) begin
            mc_valid = 1; mc_id = 6'(30 + i); mc_data = 32'h300 + i;
            tick();
        end
        vectors++; if (mc_count !== 3'd3) begin miscompares++; $display("FAIL mid_queued got %0d exp 3", mc_count); end
        reset = 1; wb_valid = 0; mc_valid = 0;
        tick();
        vectors++; if (mc_count !== 3'd0 || mc_ready !== 1'b1) begin miscompares++; $display("FAIL mid_flush got count=%0d ready=%b exp 0/1", mc_count, mc_ready); end
        vectors++; if (write_en !== 1'b0 || write_id !== 6'd0 || stall_req !== 1'b0) begin miscompares++; $display("FAIL mid_outputs got en=%b id=%0d stall=%b exp 0/0/0", write_en, write_id, stall_req); end
        reset = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++; if (write_en !== 1'b0) begin miscompares++; $display("FAIL mid_nowrite%0d got %b exp 0", i, write_en); end
        end
    endtask

    initial begin
        test_reset();
        test_wb_only();
        test_conflict();
        test_full();
        test_starvation();
        test_x0();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Shares the register file's single write port (write_en / write_id / write_data of the decode stage) between two requesters.
- Requester 1 is the main pipeline writeback (WB): priority, no backpressure.
- Requester 2 is a multi-cycle unit (MC, divider/load miss) using a valid/ready handshake, buffered in a small FIFO.
- Registered port outputs feed the register file directly. A starvation counter requests a pipeline stall so MC results always drain.

Parameters:
- DEPTH, 4, MC result FIFO entries (power of two, ≥2)
- MAX_WAIT, 8, consecutive lost-arbitration cycles before stall_req is raised (≥1)
- ID_W, 6, register id width (matches write_id)
- DATA_W, 32, register data width

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- wb_valid  in  1  WB write request this cycle
- wb_id  in  ID_W  WB destination register
- wb_data  in  DATA_W  WB write data
- mc_valid  in  1  MC result valid
- mc_ready  out  1  FIFO can accept (= not full)
- mc_id  in  ID_W  MC destination register
- mc_data  in  DATA_W  MC result data
- write_en  out  1  to register file
- write_id  out  ID_W  to register file
- write_data  out  DATA_W  to register file
- stall_req  out  1  registered; pipeline must hold wb_valid=0 in the cycle after it samples 1
- mc_count  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (sync, active-high):
  - write_en=0, write_id=0, write_data=0, stall_req=0.
  - FIFO emptied (mc_count=0, mc_ready=1), wait counter=0, FSM=ARB.
  - Applies mid-operation: buffered MC results are discarded.
- MC push: mc_valid & mc_ready pushes {mc_id, mc_data}. mc_ready = (mc_count != DEPTH), combinational from the count only. Entries with mc_id==0 are pushed then dropped silently when they reach the head; they never assert write_en.
- Grant, evaluated combinationally each cycle; the port outputs are registered, so there is 1-cycle latency from grant to write_en:
  - wb_valid=1, wb_id≠0 → WB granted; next cycle write_en=1 with wb_id/wb_data.
  - Otherwise, FIFO non-empty → head popped; if head id≠0, next cycle write_en=1 with head id/data.
  - wb_valid=1, wb_id=0 is treated as no request; the head may drain that cycle.
  - No grant → write_en=0 next cycle; write_id/write_data hold their last values.
- Simultaneous push and pop: allowed in the same cycle. Occupancy stays unchanged; a full FIFO may pop and accept a push only on the following cycle, because mc_ready is based on the count.
- FSM:
  - ARB: wait_cnt increments each cycle the head is valid and not popped, and clears on a pop or when the FIFO is empty. When wait_cnt==MAX_WAIT-1 and the head loses again → go to FORCE, stall_req=1 (registered, visible next cycle).
  - FORCE: stall_req held at 1. When the head is popped → ARB, stall_req=0 next cycle, wait_cnt=0.
  - WB still has priority in FORCE. The pipeline's honouring of stall_req guarantees a free slot.
- Write ordering: WAW ordering between WB and MC to the same register is the issuer's responsibility. The arbiter never reorders within MC (FIFO order is preserved).
- Pointers are log2(DEPTH) bits wide and wrap naturally; the count is held separately to distinguish full from empty.
- No combinational path from wb_* or mc_* to write_* or stall_req.

Decomposition:
- Shared package common: rf_write_t struct {id, data}; constants REG_ID_W=6 and DATA_W=32; arb_state_t enum {ARB, FORCE}.
- One sub-module: sync_fifo (parametric DEPTH/width, push/pop/full/empty/count), reused later for other buffers.

Test Plan:
- Reset then idle → write_en=0, stall_req=0, mc_ready=1, mc_count=0.
- WB only: wb_valid=1, wb_id=5, wb_data=0xDEADBEEF → next cycle write_en=1, write_id=5, write_data=0xDEADBEEF.
- Conflict: same cycle wb (id 3, 0x11) and mc push (id 7, 0x22) with wb_valid dropped next cycle:
  - cycle+1: write of r3.
  - cycle+2: write of r7.
  - mc_count goes 1 then 0.
- Full/backpressure: push 4 MC results while wb_valid=1 continuously (ids ≠0):
  - mc_ready=0 after the 4th push; a 5th mc_valid is not accepted.
  - Release WB: 4 writes in FIFO order on consecutive cycles.
- Starvation: 1 MC entry, wb_valid=1 for MAX_WAIT=8 cycles → stall_req=1 on cycle 9. The bench drops wb_valid → MC write next cycle, then stall_req=0.
- x0 handling and reset mid-operation:
  - wb_id=0 with an MC head id=9 → r9 written.
  - MC id=0 entry → popped, write_en=0.
  - reset asserted while 3 entries are queued → mc_count=0 and no writes afterwards.
